// File: rtl/apb4_pkg.sv
// apb4_pkg: shared APB4 widths, PPROT encodings, requester FSM states and address helper
package apb4_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] PPROT_NORMAL = 3'b000;
  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/apb4_12_32_if.sv
// APB4_12_32: APB4 bus bundle with 12-bit address and 32-bit data
//   outward: requester side (drives PADDR/PSELx/PENABLE/PWRITE/PWDATA/PSTRB/PPROT)
//   inward : completer side (drives PRDATA/PREADY/PSLVERR); PCLKEN comes from the clock owner
interface APB4_12_32;
  import apb4_pkg::*;
  logic [ADDR_W-1:0] PADDR;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [2:0]        PPROT;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              PCLKEN;
  modport outward (
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR, PCLKEN
  );
  modport inward (
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PPROT, PCLKEN,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_wait_timer.sv
// apb4_wait_timer: counts enabled wait cycles and flags the cycle on which the limit is reached
//   clk, rst_b : clock, async active-low reset
//   clr        : return count to zero (has priority over en)
//   en         : count this cycle
//   expire     : en is high and this is the LIMIT-th counted cycle (never when LIMIT=0)
module apb4_wait_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + W'(1);
  end
  // Expire on the cycle that would complete the LIMIT-th wait, so the abort lands on that edge.
  assign expire = (LIMIT != 0) && en && (count == LAST);
endmodule

// File: rtl/apb4_cmd_master.sv
// apb4_cmd_master: turns a valid/ready command stream into single APB4 transfers with a response stream
//   clk, rst_b                 : PCLK domain clock, async active-low reset
//   cmd_valid/ready            : command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_wstrb payload
//   rsp_valid/ready            : response handshake; rsp_rdata, rsp_slverr, rsp_timeout payload
//   busy                       : transfer or response outstanding
//   err_count                  : saturating count of error responses (slverr or timeout)
//   apb                        : APB4_12_32 requester port
module apb4_cmd_master
  import apb4_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 256,
  parameter logic [2:0] PPROT_VAL   = 3'b000,
  parameter int         ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [STRB_W-1:0]   cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count,
  APB4_12_32.outward          apb
);
  apb_mst_state_e state, state_nxt;
  logic              accept, xfer_done, tmr_en, abort, resp_err;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  assign cmd_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign accept    = cmd_valid & cmd_ready;
  assign xfer_done = (state == ACCESS) & apb.PCLKEN & apb.PREADY;
  assign tmr_en    = (state == ACCESS) & apb.PCLKEN & ~apb.PREADY;
  assign resp_err  = xfer_done ? apb.PSLVERR : 1'b1;
  apb4_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (state != ACCESS),
    .en     (tmr_en),
    .expire (abort)
  );
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else state <= state_nxt;
  end
  // Command acceptance is a handshake and ignores PCLKEN; only APB phase changes wait for it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? SETUP : IDLE;
      SETUP:   state_nxt = apb.PCLKEN ? ACCESS : SETUP;
      ACCESS:  state_nxt = (xfer_done | abort) ? RESP : ACCESS;
      RESP:    state_nxt = accept ? SETUP : (rsp_ready ? IDLE : RESP);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        paddr  <= word_addr(cmd_addr);
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
        pstrb  <= cmd_write ? cmd_wstrb : '0;
      end
      // A PREADY on the expiring cycle completes normally, since abort only fires with PREADY low.
      if (xfer_done | abort) begin
        rsp_rdata   <= (xfer_done & ~pwrite) ? apb.PRDATA : '0;
        rsp_slverr  <= resp_err;
        rsp_timeout <= ~xfer_done;
        if (resp_err && err_count != '1) err_count <= err_count + ERRCNT_W'(1);
      end
    end
  end
  assign rsp_valid   = state == RESP;
  assign busy        = state != IDLE;
  assign apb.PSELx   = (state == SETUP) | (state == ACCESS);
  assign apb.PENABLE = state == ACCESS;
  assign apb.PADDR   = paddr;
  assign apb.PWRITE  = pwrite;
  assign apb.PWDATA  = pwdata;
  assign apb.PSTRB   = pstrb;
  assign apb.PPROT   = PPROT_VAL;
endmodule

// File: tb/tb_apb4_cmd_master.sv
// tb_apb4_cmd_master: directed self-checking bench for apb4_cmd_master against a small APB4 memory slave
module tb_apb4_cmd_master;
  import apb4_pkg::*;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_slverr, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_count;
  int          checks = 0, errors = 0;
  APB4_12_32 apb_if ();
  apb4_cmd_master #(.TIMEOUT_CYC(4), .PPROT_VAL(3'b010), .ERRCNT_W(8)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .err_count   (err_count),
    .apb         (apb_if)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [0:1023];
  int   ws = 0, acc_cnt = 0, acc_total = 0, psel_total = 0;
  logic slv_err = 1'b0, pclk_tog = 1'b0, pclken = 1'b1;
  assign apb_if.PCLKEN  = pclken;
  assign apb_if.PREADY  = apb_if.PSELx & apb_if.PENABLE & (acc_cnt >= ws);
  assign apb_if.PSLVERR = apb_if.PREADY & slv_err;
  assign apb_if.PRDATA  = mem[apb_if.PADDR[11:2]];
  always @(posedge clk) begin
    acc_cnt <= (apb_if.PSELx & apb_if.PENABLE) ? acc_cnt + (pclken ? 1 : 0) : 0;
    if (apb_if.PSELx & apb_if.PENABLE & pclken) acc_total <= acc_total + 1;
    if (apb_if.PSELx) psel_total <= psel_total + 1;
    pclken <= pclk_tog ? ~pclken : 1'b1;
    if (apb_if.PREADY & pclken & apb_if.PWRITE & ~apb_if.PSLVERR)
      for (int b = 0; b < 4; b++)
        if (apb_if.PSTRB[b]) mem[apb_if.PADDR[11:2]][8*b +: 8] <= apb_if.PWDATA[8*b +: 8];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_wait", 64'(n < 200), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic recv(output logic [31:0] rd, output logic se, output logic to);
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("rsp_wait", 64'(n < 200), 1);
    rd = rsp_rdata; se = rsp_slverr; to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] rd;
    logic        se, to;
    int          a0, p0, n;
    repeat (2) @(negedge clk);
    chk("rst_psel_pen", 64'({apb_if.PSELx, apb_if.PENABLE, apb_if.PWRITE}), 0);
    chk("rst_paddr", 64'(apb_if.PADDR), 0);
    chk("rst_pwdata_pstrb", 64'({apb_if.PWDATA, apb_if.PSTRB}), 0);
    chk("rst_pprot", 64'(apb_if.PPROT), 'b010);
    chk("rst_rsp", 64'({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}), 0);
    chk("rst_err_busy", 64'({err_count, busy}), 0);
    rst_b = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h004; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    chk("idle_ready", 64'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wr_setup", 64'({apb_if.PSELx, apb_if.PENABLE, apb_if.PWRITE}), 'b101);
    chk("wr_paddr", 64'(apb_if.PADDR), 'h004);
    chk("wr_pwdata", 64'(apb_if.PWDATA), 'h12345678);
    chk("wr_pstrb", 64'(apb_if.PSTRB), 'hF);
    @(negedge clk);
    chk("wr_access", 64'({apb_if.PSELx, apb_if.PENABLE, rsp_valid}), 'b110);
    @(negedge clk);
    chk("wr_resp", 64'({apb_if.PSELx, apb_if.PENABLE, rsp_valid, rsp_slverr, rsp_timeout}), 'b00100);
    recv(rd, se, to);
    chk("wr_idle", 64'(busy), 0);
    send(1'b0, 12'h006, 32'hDEADBEEF, 4'hF);
    chk("rd_paddr", 64'(apb_if.PADDR), 'h004);
    chk("rd_pwdata_pstrb", 64'({apb_if.PWDATA, apb_if.PSTRB, apb_if.PWRITE}), 0);
    recv(rd, se, to);
    chk("rd_data", 64'(rd), 'h12345678);
    chk("rd_flags", 64'({se, to}), 0);
    slv_err = 1'b1;
    send(1'b0, 12'hFF0, 32'h0, 4'h0);
    chk("err_paddr", 64'(apb_if.PADDR), 'hFF0);
    recv(rd, se, to);
    slv_err = 1'b0;
    chk("err_flags", 64'({se, to}), 'b10);
    chk("err_count1", 64'(err_count), 1);
    ws = 1000; a0 = acc_total;
    send(1'b0, 12'h004, 32'h0, 4'h0);
    recv(rd, se, to);
    ws = 0;
    chk("to_flags", 64'({se, to}), 'b11);
    chk("to_rdata", 64'(rd), 0);
    chk("to_cycles", 64'(acc_total - a0), 4);
    chk("to_errcnt", 64'(err_count), 2);
    ws = 3; a0 = acc_total;
    send(1'b0, 12'h004, 32'h0, 4'h0);
    recv(rd, se, to);
    ws = 0;
    chk("ws3_flags", 64'({se, to}), 0);
    chk("ws3_rdata", 64'(rd), 'h12345678);
    chk("ws3_cycles", 64'(acc_total - a0), 4);
    chk("ws3_errcnt", 64'(err_count), 2);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h008; cmd_wdata = 32'hAAAA5555; cmd_wstrb = 4'hF;
    @(negedge clk);
    chk("b2b_setup1", 64'({apb_if.PSELx, apb_if.PENABLE, apb_if.PADDR}), {2'b10, 12'h008});
    cmd_addr = 12'h00C; cmd_wdata = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_resp1", 64'({rsp_valid, cmd_ready}), 'b11);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_setup2", 64'({apb_if.PSELx, apb_if.PENABLE, busy}), 'b101);
    chk("b2b_paddr2", 64'({apb_if.PADDR, apb_if.PWDATA}), {12'h00C, 32'h0BADF00D});
    @(negedge clk);
    @(negedge clk);
    chk("b2b_resp2", 64'(rsp_valid), 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_idle", 64'(busy), 0);
    send(1'b0, 12'h008, 32'h0, 4'h0);
    recv(rd, se, to);
    chk("b2b_rd1", 64'(rd), 'hAAAA5555);
    send(1'b0, 12'h00C, 32'h0, 4'h0);
    recv(rd, se, to);
    chk("b2b_rd2", 64'(rd), 'h0BADF00D);
    pclk_tog = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pclken && n < 10) begin @(negedge clk); n++; end
    p0 = psel_total;
    send(1'b0, 12'h00C, 32'h0, 4'h0);
    recv(rd, se, to);
    chk("pce_psel_cycles", 64'(psel_total - p0), 4);
    chk("pce_rdata", 64'(rd), 'h0BADF00D);
    pclk_tog = 1'b0;
    repeat (2) @(negedge clk);
    ws = 1000;
    send(1'b0, 12'h004, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_pre_access", 64'({apb_if.PSELx, apb_if.PENABLE}), 'b11);
    rst_b = 1'b0;
    #1;
    chk("rst_mid_apb", 64'({apb_if.PSELx, apb_if.PENABLE}), 0);
    chk("rst_mid_rsp", 64'({rsp_valid, busy}), 0);
    chk("rst_mid_err", 64'(err_count), 0);
    @(negedge clk);
    rst_b = 1'b1; ws = 0;
    @(negedge clk);
    chk("rst_after", 64'({rsp_valid, busy}), 0);
    slv_err = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 12'h010, 32'h0, 4'h0);
      recv(rd, se, to);
      if (i == 0) chk("sat_first", 64'(err_count), 1);
      if (i == 254) chk("sat_255", 64'(err_count), 255);
    end
    slv_err = 1'b0;
    chk("sat_300", 64'(err_count), 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
